coreuart_tx_async: RTL and testbench

//  Asynchronous UART transmitter, the transmit counterpart of the CoreUARTapb receive path.

---
 rtl/coreuart_tx_async_pkg.sv | 26 ++
 rtl/coreuart_tx_async.sv | 159 +++++++++++++++
 tb/tb_coreuart_tx_async.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coreuart_tx_async_pkg.sv
// Shared definitions for the asynchronous UART transmitter: state encoding,
// bit-timing constants and the parity helper.
package coreuart_tx_async_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic [3:0] TICKS_PER_BIT_M1 = 4'hF;
    localparam logic [2:0] LAST_BIT_7       = 3'd6;
    localparam logic [2:0] LAST_BIT_8       = 3'd7;

    // Parity over the bits actually sent; bit 7 is excluded in 7-bit frames.
    function automatic logic tx_parity(input logic [7:0] data,
                                       input logic       bit8,
                                       input logic       odd_n_even);
        logic [7:0] masked;
        masked = bit8 ? data : {1'b0, data[6:0]};
        return (^masked) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/coreuart_tx_async.sv
// UART transmitter: holding register fed directly or from an external FIFO,
// and a 16x-oversampled frame serialiser driving the tx pad.
module coreuart_tx_async
    import coreuart_tx_async_pkg::*;
#(
    parameter bit TX_FIFO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       write_tx_byte,
    input  logic [7:0] tx_data,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_idle
);

    tx_state_t  state_r;
    logic [3:0] tick_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] hold_r;
    logic       hold_empty_r;
    logic       cfg_bit8_r;
    logic       cfg_parity_en_r;
    logic       parity_bit_r;
    logic       tx_r;

    logic       load_s;
    logic [7:0] load_data_s;
    logic       bit_end_s;
    logic       start_s;
    logic [2:0] last_bit_s;

    generate
        if (TX_FIFO) begin : g_fifo
            logic fifo_read_r;
            logic unused_direct_s;

            // Pop one byte when the holding register is empty and no capture is pending
            always_ff @(posedge clk) begin
                if (reset) begin
                    fifo_read_r <= 1'b0;
                end else begin
                    fifo_read_r <= hold_empty_r & ~fifo_empty & ~fifo_read_r;
                end
            end

            assign load_s          = fifo_read_r;
            assign load_data_s     = fifo_data;
            assign fifo_read       = fifo_read_r;
            assign unused_direct_s = ^{write_tx_byte, tx_data};
        end else begin : g_direct
            logic unused_fifo_s;

            assign load_s        = write_tx_byte & hold_empty_r;
            assign load_data_s   = tx_data;
            assign fifo_read     = 1'b0;
            assign unused_fifo_s = ^{fifo_empty, fifo_data};
        end
    endgenerate

    assign bit_end_s  = (tick_cnt_r == TICKS_PER_BIT_M1);
    assign last_bit_s = cfg_bit8_r ? LAST_BIT_8 : LAST_BIT_7;
    // A frame starts from IDLE on any tick, or straight out of STOP with no idle gap.
    assign start_s    = baud_clock & ~hold_empty_r &
                        ((state_r == TX_IDLE) | ((state_r == TX_STOP) & bit_end_s));

    // Holding register, frame sequencer and serial output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= TX_IDLE;
            tick_cnt_r      <= 4'd0;
            bit_cnt_r       <= 3'd0;
            shift_r         <= 8'h00;
            hold_r          <= 8'h00;
            hold_empty_r    <= 1'b1;
            cfg_bit8_r      <= 1'b0;
            cfg_parity_en_r <= 1'b0;
            parity_bit_r    <= 1'b0;
            tx_r            <= 1'b1;
        end else begin
            if (load_s) begin
                hold_r       <= load_data_s;
                hold_empty_r <= 1'b0;
            end else if (start_s) begin
                hold_empty_r <= 1'b1;
            end

            if (start_s) begin
                shift_r         <= hold_r;
                cfg_bit8_r      <= bit8;
                cfg_parity_en_r <= parity_en;
                parity_bit_r    <= tx_parity(hold_r, bit8, odd_n_even);
                tx_r            <= 1'b0;
                tick_cnt_r      <= 4'd0;
                state_r         <= TX_START;
            end else if (baud_clock) begin
                tick_cnt_r <= bit_end_s ? 4'd0 : tick_cnt_r + 4'd1;
                case (state_r)
                    TX_IDLE: begin
                        tx_r <= 1'b1;
                    end
                    TX_START: begin
                        if (bit_end_s) begin
                            state_r   <= TX_DATA;
                            tx_r      <= shift_r[0];
                            bit_cnt_r <= 3'd0;
                        end
                    end
                    TX_DATA: begin
                        if (bit_end_s) begin
                            if (bit_cnt_r == last_bit_s) begin
                                if (cfg_parity_en_r) begin
                                    state_r <= TX_PARITY;
                                    tx_r    <= parity_bit_r;
                                end else begin
                                    state_r <= TX_STOP;
                                    tx_r    <= 1'b1;
                                end
                            end else begin
                                shift_r   <= {1'b0, shift_r[7:1]};
                                tx_r      <= shift_r[1];
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end
                    end
                    TX_PARITY: begin
                        if (bit_end_s) begin
                            state_r <= TX_STOP;
                            tx_r    <= 1'b1;
                        end
                    end
                    TX_STOP: begin
                        if (bit_end_s) begin
                            state_r <= TX_IDLE;
                            tx_r    <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= TX_IDLE;
                        tx_r    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx       = tx_r;
    assign tx_ready = hold_empty_r;
    assign tx_idle  = (state_r == TX_IDLE);

endmodule

// File: tb/tb_coreuart_tx_async.sv
// Bench for coreuart_tx_async: frame-level reference model compared every clk,
// directed frames sampled mid-bit, and a FIFO-fed instance looped into a bench receiver.
module tb_coreuart_tx_async;

    logic       clk;
    logic       reset;
    logic       baud_clock;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       write_tx_byte;
    logic [7:0] tx_data;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read1, tx_ready1, tx1, tx_idle1;
    logic       fifo_read2, tx_ready2, tx2, tx_idle2;

    int vectors    = 0;
    int miscompares = 0;

    coreuart_tx_async #(.TX_FIFO(1'b0)) dut_direct (
        .clk(clk), .reset(reset), .baud_clock(baud_clock),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .write_tx_byte(write_tx_byte), .tx_data(tx_data),
        .fifo_empty(1'b1), .fifo_data(8'h00),
        .fifo_read(fifo_read1), .tx_ready(tx_ready1), .tx(tx1), .tx_idle(tx_idle1)
    );

    coreuart_tx_async #(.TX_FIFO(1'b1)) dut_fifo (
        .clk(clk), .reset(reset), .baud_clock(baud_clock),
        .bit8(1'b1), .parity_en(1'b1), .odd_n_even(1'b1),
        .write_tx_byte(1'b0), .tx_data(8'h00),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(fifo_read2), .tx_ready(tx_ready2), .tx(tx2), .tx_idle(tx_idle2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line levels of one frame, index 0 = start bit; positions past the frame read as idle 1.
    function automatic logic [10:0] frame_levels(input logic [7:0] d, input logic b8,
                                                 input logic pe, input logic odd);
        logic [10:0] v;
        int          n;
        int          i;
        logic        p;
        v = '1;
        n = b8 ? 8 : 7;
        v[0] = 1'b0;
        i = 1;
        p = odd;
        for (int k = 0; k < n; k++) begin
            v[i] = d[k];
            p    = p ^ d[k];
            i++;
        end
        if (pe) begin
            v[i] = p;
            i++;
        end
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int frame_len(input logic b8, input logic pe);
        return 2 + (b8 ? 8 : 7) + (pe ? 1 : 0);
    endfunction

    // Reference model: a frame is a list of levels, each held for 16 ticks.
    bit          m_hold_full = 1'b0;
    logic [7:0]  m_hold      = 8'h00;
    bit          m_busy      = 1'b0;
    bit          m_tx        = 1'b1;
    logic [10:0] m_lv;
    int          m_len, m_idx, m_left;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_hold_full = 1'b0;
                m_busy      = 1'b0;
                m_tx        = 1'b1;
            end else begin
                bit hf;
                bit start;
                hf    = m_hold_full;
                start = 1'b0;
                if (baud_clock) begin
                    if (m_busy) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_idx++;
                            if (m_idx < m_len) begin
                                m_tx   = m_lv[m_idx];
                                m_left = 16;
                            end else begin
                                m_busy = 1'b0;
                                m_tx   = 1'b1;
                                start  = hf;
                            end
                        end
                    end else begin
                        start = hf;
                    end
                    if (start) begin
                        m_lv        = frame_levels(m_hold, bit8, parity_en, odd_n_even);
                        m_len       = frame_len(bit8, parity_en);
                        m_idx       = 0;
                        m_left      = 16;
                        m_tx        = 1'b0;
                        m_busy      = 1'b1;
                        m_hold_full = 1'b0;
                    end
                end
                if (write_tx_byte && !hf) begin
                    m_hold      = tx_data;
                    m_hold_full = 1'b1;
                end
            end
            #1;
            check("tx", tx1, m_tx);
            check("tx_ready", tx_ready1, !m_hold_full);
            check("tx_idle", tx_idle1, !m_busy);
            check("fifo_read_direct", fifo_read1, 1'b0);
        end
    end

    initial begin
        baud_clock = 1'b0;
        forever begin
            @(negedge clk);
            baud_clock = $urandom_range(0, 1);
        end
    end

    int tick_no   = 0;
    int pop_count = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (baud_clock) tick_no++;
            if (fifo_read2) pop_count++;
        end
    end

    // External FIFO: head data appears the clk after a pop.
    logic [7:0] fq[$];
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (fifo_read2 && fq.size() > 0) fifo_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    end

    // Receiver for the FIFO instance (8 data bits, odd parity), sampling at mid-bit.
    logic [7:0] rx_q[$];
    bit         perr_q[$];
    bit         ferr_q[$];
    initial begin
        bit         rx_active;
        int         rx_s;
        int         rx_k;
        logic [7:0] rx_byte;
        logic       rx_par;
        rx_active = 1'b0;
        rx_s = 0;
        rx_k = 0;
        rx_byte = 8'h00;
        rx_par = 1'b0;
        forever begin
            @(negedge clk);
            if (!rx_active) begin
                if (tx2 === 1'b0) begin
                    rx_active = 1'b1;
                    rx_s      = tick_no;
                    rx_k      = 1;
                end
            end else if (tick_no - rx_s == 16 * rx_k + 8) begin
                if (rx_k <= 8) begin
                    rx_byte[rx_k-1] = tx2;
                end else if (rx_k == 9) begin
                    rx_par = tx2;
                end else begin
                    rx_q.push_back(rx_byte);
                    perr_q.push_back(rx_par !== ((^rx_byte) ^ 1'b1));
                    ferr_q.push_back(tx2 !== 1'b1);
                    rx_active = 1'b0;
                end
                rx_k++;
            end
        end
    end

    task automatic wait_tick();
        int g;
        g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (baud_clock !== 1'b1 && g < 100);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic do_write(input logic [7:0] d);
        @(negedge clk);
        tx_data       = d;
        write_tx_byte = 1'b1;
        @(negedge clk);
        write_tx_byte = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (tx_idle1 !== 1'b1 && g < 4000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(name, tx_idle1, 1'b1);
    endtask

    // Wait for the start edge, then sample every bit at its midpoint against literal levels.
    task automatic check_frame(input string name, input logic [10:0] lit, input int n);
        int g;
        g = 0;
        while (tx1 !== 1'b0 && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check({name, "_start"}, tx1, 1'b0);
        wait_ticks(8);
        check({name, "_bit0"}, tx1, lit[0]);
        for (int i = 1; i < n; i++) begin
            wait_ticks(16);
            check($sformatf("%s_bit%0d", name, i), tx1, lit[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        bit8 = 1'b1;
        parity_en = 1'b0;
        odd_n_even = 1'b0;
        write_tx_byte = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_tx", tx1, 1'b1);
        check("rst_tx_ready", tx_ready1, 1'b1);
        check("rst_tx_idle", tx_idle1, 1'b1);
        check("rst_fifo_read", fifo_read1, 1'b0);
        check("rst_fifo_read2", fifo_read2, 1'b0);
        check("rst_tx2", tx2, 1'b1);

        check("pin_8n1_a5", frame_levels(8'hA5, 1'b1, 1'b0, 1'b0), 11'b11101001010);
        check("pin_7e1_c1", frame_levels(8'hC1, 1'b0, 1'b1, 1'b0), 11'b11010000010);
        check("pin_8o1_03", frame_levels(8'h03, 1'b1, 1'b1, 1'b1), 11'b11000000110);
        check("pin_8e1_03", frame_levels(8'h03, 1'b1, 1'b1, 1'b0), 11'b10000000110);
        check("pin_len_7e1", frame_len(1'b0, 1'b1), 32'd10);

        // 8N1 0xA5
        do_write(8'hA5);
        check_frame("f8n1_a5", 11'b11101001010, 10);
        wait_idle("f8n1_a5_idle");

        // 7E1 0xC1: bit 7 dropped
        @(negedge clk);
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
        do_write(8'hC1);
        check_frame("f7e1_c1", 11'b11010000010, 10);
        wait_idle("f7e1_c1_idle");

        // 8O1 / 8E1 0x03
        @(negedge clk);
        bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
        do_write(8'h03);
        check_frame("f8o1_03", 11'b11000000110, 11);
        wait_idle("f8o1_03_idle");
        @(negedge clk);
        odd_n_even = 1'b0;
        do_write(8'h03);
        check_frame("f8e1_03", 11'b10000000110, 11);
        wait_idle("f8e1_03_idle");

        // Back-to-back frames; a write while full is dropped
        @(negedge clk);
        parity_en = 1'b0;
        do_write(8'h3C);
        wait_ticks(40);
        do_write(8'h96);
        check("b2b_full", tx_ready1, 1'b0);
        do_write(8'h11);
        wait_idle("b2b_idle");

        // Reset mid-DATA, then a clean 0x55 frame
        do_write(8'h7E);
        wait_ticks(40);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", tx1, 1'b1);
        check("midrst_tx_ready", tx_ready1, 1'b1);
        check("midrst_tx_idle", tx_idle1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        do_write(8'h55);
        check_frame("f8n1_55", 11'b11010101010, 10);
        wait_idle("f8n1_55_idle");

        // FIFO-fed instance, looped into the bench receiver
        pop_count = 0;
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        fq.push_back(8'h5A);
        begin
            int g;
            g = 0;
            while (rx_q.size() < 3 && g < 10000) begin
                @(posedge clk);
                g++;
            end
        end
        check("fifo_rx_count", rx_q.size(), 32'd3);
        check("fifo_pops", pop_count, 32'd3);
        if (rx_q.size() == 3) begin
            check("fifo_rx0", rx_q[0], 8'h00);
            check("fifo_rx1", rx_q[1], 8'hFF);
            check("fifo_rx2", rx_q[2], 8'h5A);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("fifo_parity_err%0d", i), perr_q[i], 1'b0);
                check($sformatf("fifo_framing_err%0d", i), ferr_q[i], 1'b0);
            end
        end

        // Randomized traffic, config churn and occasional resets
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            write_tx_byte = ($urandom_range(0, 39) == 0);
            tx_data       = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                bit8       = 1'($urandom);
                parity_en  = 1'($urandom);
                odd_n_even = 1'($urandom);
            end
            reset = ($urandom_range(0, 2999) == 0);
        end
        @(negedge clk);
        write_tx_byte = 1'b0;
        reset = 1'b0;
        wait_idle("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
